reminder_beeper: RTL and testbench

- Downstream consumer of the hood controller's `cleaning_reminder` level; drives the piezo `speaker` pin.
- While the reminder is asserted, plays a repeating pattern of BEEP_COUNT tone bursts followed by a silent pause.
- Provides a mute input (user acknowledge) and status outputs for LEDs/debug.

---
 rtl/reminder_beeper.sv | 134 +++++++++++++
 tb/tb_reminder_beeper.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reminder_beeper.sv
// reminder_beeper: plays groups of BEEP_COUNT square-wave tone bursts, each
// group followed by a silent pause, while the cleaning reminder is held.
// A mute pulse silences the current reminder episode until reminder drops.
module reminder_beeper #(
  parameter int unsigned TONE_HALF  = 25000,
  parameter int unsigned BEEP_CYC   = 20000000,
  parameter int unsigned GAP_CYC    = 20000000,
  parameter int unsigned PAUSE_CYC  = 200000000,
  parameter int unsigned BEEP_COUNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reminder,
  input  logic       mute,
  output logic       speaker,
  output logic       active,
  output logic [3:0] beep_idx
);

  localparam int unsigned MAX_BG  = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
  localparam int unsigned MAX_CYC = (MAX_BG > PAUSE_CYC) ? MAX_BG : PAUSE_CYC;
  localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned NW      = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

  localparam logic [TW-1:0] BEEP_LAST  = TW'(BEEP_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] PAUSE_LAST = TW'(PAUSE_CYC - 1);
  localparam logic [NW-1:0] TONE_LAST  = NW'(TONE_HALF - 1);
  localparam logic [3:0]    IDX_LAST   = 4'(BEEP_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEEP,
    S_GAP,
    S_PAUSE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [NW-1:0] tone_q,  tone_d;
  logic          spk_q,   spk_d;
  logic [3:0]    idx_q,   idx_d;
  logic          muted_q, muted_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      tone_q  <= '0;
      spk_q   <= 1'b0;
      idx_q   <= '0;
      muted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      tone_q  <= tone_d;
      spk_q   <= spk_d;
      idx_q   <= idx_d;
      muted_q <= muted_d;
    end
  end

  // Next state: phase sequencing, tone generation and mute bookkeeping.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    tone_d  = '0;
    spk_d   = 1'b0;
    idx_d   = idx_q;
    muted_d = muted_q;

    if (!reminder) begin
      muted_d = 1'b0;
    end else if (mute) begin
      muted_d = 1'b1;
    end

    // Dropped reminder, a mute pulse or a muted episode all force silence;
    // mute beats a same-cycle reminder rise because this check comes first.
    if (!reminder || mute || muted_q) begin
      state_d = S_IDLE;
      timer_d = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_BEEP;
          timer_d = '0;
          idx_d   = '0;
        end
        S_BEEP: begin
          if (timer_q == BEEP_LAST) begin
            timer_d = '0;
            state_d = (idx_q < IDX_LAST) ? S_GAP : S_PAUSE;
          end else if (tone_q == TONE_LAST) begin
            tone_d = '0;
            spk_d  = ~spk_q;
          end else begin
            tone_d = tone_q + 1'b1;
            spk_d  = spk_q;
          end
        end
        S_GAP: begin
          if (timer_q == GAP_LAST) begin
            state_d = S_BEEP;
            timer_d = '0;
            idx_d   = idx_q + 4'd1;
          end
        end
        S_PAUSE: begin
          if (timer_q == PAUSE_LAST) begin
            state_d = S_BEEP;
            timer_d = '0;
            idx_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Outputs: speaker and index come straight from registers.
  always_comb begin
    active   = (state_q != S_IDLE);
    speaker  = spk_q;
    beep_idx = idx_q;
  end

endmodule

// File: tb/tb_reminder_beeper.sv
// Bench for reminder_beeper: a vector table with hand-written corner
// sequences, then random stimulus checked against an episode-time model.
module tb_reminder_beeper;

  localparam int TH = 2;
  localparam int BC = 8;
  localparam int GC = 4;
  localparam int PC = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rem = 1'b0;
  logic       mte = 1'b0;
  logic       spk_a, act_a, spk_b, act_b;
  logic [3:0] idx_a, idx_b;

  int n_tests = 0;
  int n_fail  = 0;
  int b_idx_nz = 0;

  // Model state: whether an episode is sounding, and cycles since it began.
  bit run_m   = 1'b0;
  bit muted_m = 1'b0;
  int t_m     = 0;

  reminder_beeper #(
    .TONE_HALF(TH), .BEEP_CYC(BC), .GAP_CYC(GC), .PAUSE_CYC(PC), .BEEP_COUNT(3)
  ) dut_a (
    .clk(clk), .reset(rst), .reminder(rem), .mute(mte),
    .speaker(spk_a), .active(act_a), .beep_idx(idx_a)
  );

  reminder_beeper #(
    .TONE_HALF(TH), .BEEP_CYC(BC), .GAP_CYC(GC), .PAUSE_CYC(PC), .BEEP_COUNT(1)
  ) dut_b (
    .clk(clk), .reset(rst), .reminder(rem), .mute(mte),
    .speaker(spk_b), .active(act_b), .beep_idx(idx_b)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int         ncyc;
    bit         rst;
    bit         rem;
    bit         mute;
    bit         spk;
    bit         act;
    logic [3:0] idx;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Expected {speaker, active, idx} from position in the repeating group.
  function automatic logic [5:0] model_out(input bit run, input int t, input int bcount);
    int period, burst_span, p, k, off;
    if (!run) return 6'h00;
    burst_span = bcount * BC + (bcount - 1) * GC;
    period     = burst_span + PC;
    p          = t % period;
    if (p < burst_span) begin
      k   = p / (BC + GC);
      off = p % (BC + GC);
      if (off < BC) return {1'b1 & 1'((off / TH) % 2), 1'b1, 4'(k)};
      return {1'b0, 1'b1, 4'(k)};
    end
    return {1'b0, 1'b1, 4'(bcount - 1)};
  endfunction

  task automatic model_update();
    bit mo;
    mo = muted_m;
    if (rst) begin
      run_m = 1'b0; muted_m = 1'b0; t_m = 0;
    end else begin
      if (!rem) muted_m = 1'b0;
      else if (mte) muted_m = 1'b1;
      if (!rem || mte || mo) begin
        run_m = 1'b0; t_m = 0;
      end else if (!run_m) begin
        run_m = 1'b1; t_m = 0;
      end else begin
        t_m++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    chk("model_a", {2'b00, spk_a, act_a, idx_a}, {2'b00, model_out(run_m, t_m, 3)});
    chk("model_b", {2'b00, spk_b, act_b, idx_b}, {2'b00, model_out(run_m, t_m, 1)});
    if (idx_b != 4'd0) b_idx_nz++;
  endtask

  task automatic drive(input bit r, input bit re, input bit m);
    rst = r; rem = re; mte = m;
  endtask

  initial begin
    int silent_bad;

    // {ncyc, reset, reminder, mute, exp speaker, exp active, exp idx}
    tbl.push_back('{2, 1, 0, 0, 0, 0, 4'd0});  // reset state
    tbl.push_back('{1, 0, 0, 0, 0, 0, 4'd0});  // idle
    tbl.push_back('{1, 0, 1, 0, 0, 1, 4'd0});  // c1 burst 0 begins
    tbl.push_back('{2, 0, 1, 0, 1, 1, 4'd0});  // c3 first toggle
    tbl.push_back('{2, 0, 1, 0, 0, 1, 4'd0});  // c5
    tbl.push_back('{2, 0, 1, 0, 1, 1, 4'd0});  // c7
    tbl.push_back('{1, 0, 1, 0, 1, 1, 4'd0});  // c8 last burst cycle
    tbl.push_back('{1, 0, 1, 0, 0, 1, 4'd0});  // c9 gap
    tbl.push_back('{3, 0, 1, 0, 0, 1, 4'd0});  // c12 gap end
    tbl.push_back('{1, 0, 1, 0, 0, 1, 4'd1});  // c13 burst 1
    tbl.push_back('{2, 0, 1, 0, 1, 1, 4'd1});  // c15
    tbl.push_back('{10, 0, 1, 0, 0, 1, 4'd2}); // c25 burst 2
    tbl.push_back('{7, 0, 1, 0, 1, 1, 4'd2});  // c32
    tbl.push_back('{1, 0, 1, 0, 0, 1, 4'd2});  // c33 pause
    tbl.push_back('{9, 0, 1, 0, 0, 1, 4'd2});  // c42 pause end
    tbl.push_back('{1, 0, 1, 0, 0, 1, 4'd0});  // c43 group repeats
    tbl.push_back('{2, 0, 1, 0, 1, 1, 4'd0});  // c45 mid burst
    tbl.push_back('{1, 0, 0, 0, 0, 0, 4'd0});  // reminder dropped: truncated
    tbl.push_back('{1, 0, 1, 0, 0, 1, 4'd0});  // restarts at burst 0
    tbl.push_back('{2, 0, 1, 0, 1, 1, 4'd0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 4'd0});
    tbl.push_back('{1, 0, 1, 1, 0, 0, 4'd0});  // mute with rising reminder
    tbl.push_back('{20, 0, 1, 0, 0, 0, 4'd0}); // stays silent
    tbl.push_back('{1, 0, 0, 0, 0, 0, 4'd0});
    tbl.push_back('{1, 0, 1, 0, 0, 1, 4'd0});
    tbl.push_back('{33, 0, 1, 0, 0, 1, 4'd2}); // c34 in pause
    tbl.push_back('{1, 1, 1, 0, 0, 0, 4'd0});  // reset mid pause
    tbl.push_back('{1, 0, 1, 0, 0, 1, 4'd0});  // beeps one cycle after release
    tbl.push_back('{1, 0, 0, 0, 0, 0, 4'd0});
    tbl.push_back('{1, 0, 1, 0, 0, 1, 4'd0});
    tbl.push_back('{8, 0, 1, 0, 0, 1, 4'd0});  // c9 gap
    tbl.push_back('{1, 0, 1, 1, 0, 0, 4'd0});  // mute in gap

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].rem, tbl[i].mute);
      for (int c = 0; c < tbl[i].ncyc; c++) tick();
      chk($sformatf("vec%0d", i), {2'b00, spk_a, act_a, idx_a},
          {2'b00, tbl[i].spk, tbl[i].act, tbl[i].idx});
    end

    // Muted episode stays silent while reminder is held.
    drive(0, 1, 0);
    silent_bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (spk_a || act_a) silent_bad++;
    end
    chk("muted_silent_cycles", 8'(silent_bad), 8'd0);
    drive(0, 0, 0);
    tick();
    drive(0, 1, 0);
    tick();
    chk("unmute_resume", {2'b00, spk_a, act_a, idx_a}, {2'b00, 1'b0, 1'b1, 4'd0});
    tick(); tick();
    chk("unmute_tone", {7'd0, spk_a}, 8'd1);

    // Single-burst groups go straight to pause.
    drive(0, 0, 0);
    tick();
    drive(0, 1, 0);
    tick();
    chk("b1_burst", {2'b00, spk_b, act_b, idx_b}, {2'b00, 1'b0, 1'b1, 4'd0});
    for (int c = 0; c < 8; c++) tick();
    chk("b1_pause", {2'b00, spk_b, act_b, idx_b}, {2'b00, 1'b0, 1'b1, 4'd0});
    for (int c = 0; c < 10; c++) tick();
    chk("b1_repeat", {2'b00, spk_b, act_b, idx_b}, {2'b00, 1'b0, 1'b1, 4'd0});
    tick(); tick();
    chk("b1_tone", {7'd0, spk_b}, 8'd1);

    // Random phase.
    for (int c = 0; c < 2500; c++) begin
      bit r, m, x;
      r = rem;
      if ($urandom_range(0, 119) == 0) r = ~r;
      m = ($urandom_range(0, 299) == 0);
      x = ($urandom_range(0, 799) == 0);
      drive(x, r, m);
      tick();
    end

    chk("b1_idx_never_nonzero", 8'(b_idx_nz), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
